passcode_checker: RTL and testbench

Passcode entry and verification FSM for the security device. Consumes one-cycle digit/enter/clear strobes produced by the keypad's level-to-pulse stage, plus a one-cycle `tick` strobe derived from the clock divider. Buffers entered digits, compares them against a stored code, and drives the unlock, error and alarm indications. Enforces an inactivity timeout, an unlock hold time, and a lockout after repeated failures.

---
 rtl/passcode_checker.sv | 153 +++++++++++++++
 tb/tb_passcode_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/passcode_checker.sv
// Keypad passcode entry/verification FSM with inactivity timeout, timed
// unlock and lockout after repeated failed checks.
module passcode_checker #(
  parameter int DIGITS        = 4,
  parameter int MAX_TRIES     = 3,
  parameter int TIMEOUT_TICKS = 10,
  parameter int UNLOCK_TICKS  = 5,
  parameter int LOCKOUT_TICKS = 30,
  parameter int TICK_BITS     = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             digit_pulse,
  input  logic [3:0]                       digit,
  input  logic                             enter_pulse,
  input  logic                             clear_pulse,
  input  logic                             tick,
  input  logic [4*DIGITS-1:0]              stored_code,
  output logic                             unlock,
  output logic                             error,
  output logic                             alarm,
  output logic [$clog2(DIGITS+1)-1:0]      entry_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam logic [CW-1:0]        DIGITS_C  = CW'(DIGITS);
  localparam logic [FW-1:0]        TRIES_C   = FW'(MAX_TRIES);
  localparam logic [TICK_BITS-1:0] TIMEOUT_C = TICK_BITS'(TIMEOUT_TICKS);
  localparam logic [TICK_BITS-1:0] UNLOCK_C  = TICK_BITS'(UNLOCK_TICKS);
  localparam logic [TICK_BITS-1:0] LOCKOUT_C = TICK_BITS'(LOCKOUT_TICKS);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_LOCKOUT
  } state_t;

  state_t                r_state;
  logic [4*DIGITS-1:0]   r_buf;
  logic [CW-1:0]         r_cnt;
  logic [FW-1:0]         r_fail;
  logic [TICK_BITS-1:0]  r_tick;
  logic                  r_error;

  logic                  w_digit_ok;
  logic                  w_match;
  logic [TICK_BITS-1:0]  w_tick_next;
  logic [FW-1:0]         w_fail_next;

  assign w_digit_ok  = digit_pulse && (digit <= 4'd9);
  assign w_match     = (r_cnt == DIGITS_C) && (r_buf == stored_code);
  assign w_tick_next = r_tick + 1'b1;
  assign w_fail_next = (r_fail == TRIES_C) ? r_fail : r_fail + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_fail  <= '0;
      r_tick  <= '0;
      r_error <= 1'b0;
    end else begin
      // NOTE: error defaults low every cycle so a set in CHECK is a single-cycle pulse.
      r_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_digit_ok) begin
            r_buf   <= {{(4*DIGITS-4){1'b0}}, digit};
            r_cnt   <= CW'(1);
            r_tick  <= '0;
            r_state <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (clear_pulse) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_tick  <= '0;
            r_state <= S_IDLE;
          end else if (enter_pulse) begin
            r_state <= S_CHECK;
          end else if (w_digit_ok) begin
            // Extra digits past a full buffer only restart the timeout.
            if (r_cnt < DIGITS_C) begin
              r_buf <= {r_buf[4*DIGITS-5:0], digit};
              r_cnt <= r_cnt + 1'b1;
            end
            r_tick <= '0;
          end else if (tick) begin
            if (w_tick_next == TIMEOUT_C) begin
              r_buf   <= '0;
              r_cnt   <= '0;
              r_tick  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_tick <= w_tick_next;
            end
          end
        end

        S_CHECK: begin
          r_buf  <= '0;
          r_cnt  <= '0;
          r_tick <= '0;
          if (w_match) begin
            r_fail  <= '0;
            r_state <= S_UNLOCKED;
          end else begin
            r_fail <= w_fail_next;
            if (w_fail_next == TRIES_C) begin
              r_state <= S_LOCKOUT;
            end else begin
              r_error <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end

        S_UNLOCKED: begin
          if (clear_pulse || (tick && (w_tick_next == UNLOCK_C))) begin
            r_tick  <= '0;
            r_state <= S_IDLE;
          end else if (tick) begin
            r_tick <= w_tick_next;
          end
        end

        S_LOCKOUT: begin
          if (tick) begin
            if (w_tick_next == LOCKOUT_C) begin
              r_tick  <= '0;
              r_fail  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_tick <= w_tick_next;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign unlock      = (r_state == S_UNLOCKED);
  assign alarm       = (r_state == S_LOCKOUT);
  assign error       = r_error;
  assign entry_count = r_cnt;
  assign fail_count  = r_fail;

endmodule

// File: tb/tb_passcode_checker.sv
// Directed self-checking bench for passcode_checker; inputs change and
// outputs are sampled on the falling clock edge.
module tb_passcode_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        digit_pulse;
  logic [3:0]  digit;
  logic        enter_pulse;
  logic        clear_pulse;
  logic        tick;
  logic [15:0] stored_code;
  logic        unlock;
  logic        error;
  logic        alarm;
  logic [2:0]  entry_count;
  logic [1:0]  fail_count;

  int n_cmp = 0;
  int n_err = 0;

  passcode_checker dut (
    .clk         (clk),
    .reset       (reset),
    .digit_pulse (digit_pulse),
    .digit       (digit),
    .enter_pulse (enter_pulse),
    .clear_pulse (clear_pulse),
    .tick        (tick),
    .stored_code (stored_code),
    .unlock      (unlock),
    .error       (error),
    .alarm       (alarm),
    .entry_count (entry_count),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    digit_pulse = 1'b1;
    digit       = d;
    @(negedge clk);
    digit_pulse = 1'b0;
  endtask

  task automatic code4(input logic [15:0] c);
    key(c[15:12]);
    key(c[11:8]);
    key(c[7:4]);
    key(c[3:0]);
  endtask

  // Enter strobe, then advance to the cycle where the CHECK outcome shows.
  task automatic submit();
    enter_pulse = 1'b1;
    @(negedge clk);
    enter_pulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear();
    clear_pulse = 1'b1;
    @(negedge clk);
    clear_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; digit_pulse = 1'b0; digit = 4'd0; enter_pulse = 1'b0;
    clear_pulse = 1'b0; tick = 1'b0; stored_code = 16'h1234;
    idle(2);
    check("rst_unlock", 16'(unlock), 16'd0);
    check("rst_error",  16'(error),  16'd0);
    check("rst_alarm",  16'(alarm),  16'd0);
    check("rst_count",  16'(entry_count), 16'd0);
    check("rst_fail",   16'(fail_count),  16'd0);
    reset = 1'b0;
    idle(1);

    // Correct code, unlock held for 5 ticks
    key(4'd1);
    check("cnt_after_1", 16'(entry_count), 16'd1);
    key(4'd2); key(4'd3); key(4'd4);
    check("cnt_after_4", 16'(entry_count), 16'd4);
    enter_pulse = 1'b1; @(negedge clk); enter_pulse = 1'b0;
    check("check_cycle_unlock", 16'(unlock), 16'd0);
    @(negedge clk);
    check("ok_unlock", 16'(unlock), 16'd1);
    check("ok_fail",   16'(fail_count), 16'd0);
    check("ok_count",  16'(entry_count), 16'd0);
    check("ok_error",  16'(error), 16'd0);
    ticks(4);
    check("unlock_4_ticks", 16'(unlock), 16'd1);
    ticks(1);
    check("unlock_5_ticks", 16'(unlock), 16'd0);

    // Overlong entry: fifth digit ignored; clear relocks immediately
    code4(16'h1234); key(4'd5);
    check("overlong_cnt", 16'(entry_count), 16'd4);
    submit();
    check("overlong_unlock", 16'(unlock), 16'd1);
    clear();
    check("clear_relock", 16'(unlock), 16'd0);

    // Short entry -> single error pulse
    key(4'd1); key(4'd2); key(4'd3);
    submit();
    check("short_error", 16'(error), 16'd1);
    check("short_fail",  16'(fail_count), 16'd1);
    check("short_unlock", 16'(unlock), 16'd0);
    idle(1);
    check("short_error_drop", 16'(error), 16'd0);

    // Lockout: clear fail count with a good entry, then three wrong entries
    code4(16'h1234); submit(); clear();
    check("fail_cleared", 16'(fail_count), 16'd0);
    code4(16'h9999); submit();
    check("wrong1_error", 16'(error), 16'd1);
    check("wrong1_fail",  16'(fail_count), 16'd1);
    code4(16'h9999); submit();
    check("wrong2_error", 16'(error), 16'd1);
    check("wrong2_fail",  16'(fail_count), 16'd2);
    code4(16'h9999); submit();
    check("wrong3_alarm", 16'(alarm), 16'd1);
    check("wrong3_error", 16'(error), 16'd0);
    check("wrong3_fail",  16'(fail_count), 16'd3);
    key(4'd5);
    check("lockout_digit_cnt", 16'(entry_count), 16'd0);
    ticks(29);
    check("lockout_29", 16'(alarm), 16'd1);
    ticks(1);
    check("lockout_30_alarm", 16'(alarm), 16'd0);
    check("lockout_30_fail",  16'(fail_count), 16'd0);

    // Timeout; invalid digit does not restart it
    key(4'd1); key(4'd2);
    ticks(9);
    check("to_9_cnt", 16'(entry_count), 16'd2);
    key(4'hA);
    check("to_hexA_cnt", 16'(entry_count), 16'd2);
    ticks(1);
    check("to_10_cnt", 16'(entry_count), 16'd0);

    // Digit coinciding with tick wins and restarts the count
    key(4'd1);
    ticks(9);
    tick = 1'b1; key(4'd2); tick = 1'b0;
    check("dt_cnt", 16'(entry_count), 16'd2);
    ticks(9);
    check("dt_9_cnt", 16'(entry_count), 16'd2);
    ticks(1);
    check("dt_10_cnt", 16'(entry_count), 16'd0);

    // Clear beats enter
    code4(16'h1234);
    clear_pulse = 1'b1; enter_pulse = 1'b1; @(negedge clk);
    clear_pulse = 1'b0; enter_pulse = 1'b0;
    check("prio_cnt", 16'(entry_count), 16'd0);
    @(negedge clk);
    check("prio_unlock", 16'(unlock), 16'd0);
    check("prio_error",  16'(error),  16'd0);
    submit();
    check("idle_enter_unlock", 16'(unlock), 16'd0);
    check("idle_enter_error",  16'(error),  16'd0);

    // Reset mid-lockout, strobes during reset ignored
    code4(16'h9999); submit();
    code4(16'h9999); submit();
    code4(16'h9999); submit();
    check("rl_alarm", 16'(alarm), 16'd1);
    ticks(5);
    reset = 1'b1; digit_pulse = 1'b1; digit = 4'd1;
    @(negedge clk);
    digit_pulse = 1'b0;
    check("rl_alarm_clr", 16'(alarm), 16'd0);
    check("rl_fail_clr",  16'(fail_count), 16'd0);
    check("rl_cnt",       16'(entry_count), 16'd0);
    reset = 1'b0;
    idle(1);
    code4(16'h1234); submit();
    check("rl_unlock", 16'(unlock), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
